// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 control sequencer: owns pc/IR, fetches over a req/ready handshake,
// steps decode/execute/mem/writeback and gates architectural write enables.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// BOOT      | one-cycle settle after reset
// FETCH     | imem_req high, wait for imem_ready, latch instruction
// DECODE    | decoder settles; illegal opcode diverts to HALT
// EXECUTE   | branches resolve here; loads/stores go on to MEM
// MEM       | dmem_req high (dmem_we for stores) until dmem_ready
// WRITEBACK | single-cycle gated register-file write
// HALT      | sticky stop on illegal opcode, cleared only by reset
module multicycle_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  input  logic [6:0]  opcode,
  input  logic        dec_rf_wr_en,
  input  logic        dec_jump,
  input  logic        dec_branch,
  input  logic        branch_cond,
  input  logic [31:0] immediate,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_wr_en,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_BOOT      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        retire_q, retire_d;
  logic        pc_upd;
  logic        legal;
  logic        is_store;
  logic        take_imm;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_JAL, OP_LUI, OP_BR, OP_STORE, OP_LOAD: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign is_store = (opcode == OP_STORE);
  assign take_imm = dec_jump | (dec_branch & branch_cond);

  always_comb begin
    state_d  = state_q;
    pc_upd   = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_wr_en = 1'b0;
    case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = S_DECODE;
      end
      S_DECODE: state_d = legal ? S_EXECUTE : S_HALT;
      S_EXECUTE: begin
        if (is_store || opcode == OP_LOAD) begin
          state_d = S_MEM;
        end else if (opcode == OP_BR) begin
          pc_upd  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_upd  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        rf_wr_en = dec_rf_wr_en;
        pc_upd   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_BOOT;
    endcase
  end

  // pc, instret and retire all move on the edge that leaves an instruction's final state
  always_comb begin
    pc_d      = pc_upd ? (pc_q + (take_imm ? immediate : 32'd4)) : pc_q;
    instr_d   = (state_q == S_FETCH && imem_ready) ? imem_rdata : instr_q;
    instret_d = pc_upd ? (instret_q + 32'd1) : instret_q;
    retire_d  = pc_upd;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      instret_q <= 32'd0;
      retire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      retire_q  <= retire_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign instret     = instret_q;
  assign retire      = retire_q;
  assign state       = state_q;
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: runs hand-scored instructions through the
// fetch/mem handshakes and checks latency, gated strobes, pc flow, halt and reset.
module tb_multicycle_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic        dec_rf_wr_en = 1'b0;
  logic        dec_jump = 1'b0;
  logic        dec_branch = 1'b0;
  logic        branch_cond = 1'b0;
  logic [31:0] immediate = 32'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready = 1'b0;
  logic        rf_wr_en;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        retire;
  logic [31:0] instret;
  logic        halted;

  int          total = 0;
  int          bad = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  always #5 clock = ~clock;

  // decoder opcode field is a straight slice of the IR
  assign opcode = instruction[6:0];

  multicycle_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .opcode       (opcode),
    .dec_rf_wr_en (dec_rf_wr_en),
    .dec_jump     (dec_jump),
    .dec_branch   (dec_branch),
    .branch_cond  (branch_cond),
    .immediate    (immediate),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ready   (dmem_ready),
    .rf_wr_en     (rf_wr_en),
    .pc           (pc),
    .state        (state),
    .retire       (retire),
    .instret      (instret),
    .halted       (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clock); #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_strobes", {27'd0, imem_req, dmem_req, dmem_we, rf_wr_en, retire}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk("boot_state", {29'd0, state}, 32'd0);
    chk("boot_noreq", {31'd0, imem_req}, 32'd0);
    @(posedge clock); #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    m_pc = 32'd0;
    m_ret = 32'd0;
  endtask

  // Runs one instruction from its first FETCH cycle to the first FETCH of the next one.
  task automatic exec(input string tag, input logic [31:0] word, input logic rfw,
                      input logic jmp, input logic br, input logic cond,
                      input logic [31:0] imm, input int iw, input int dw, input logic noise,
                      input int exp_cyc, input int exp_rf, input int exp_rfcyc,
                      input int exp_dreq, input int exp_we);
    int cyc = 0;
    int rf = 0;
    int rfc = 0;
    int dreq = 0;
    int we = 0;
    int abad = 0;
    int rets = 0;
    int iwc = 0;
    int dwc = 0;
    logic left = 1'b0;
    logic [31:0] npc;
    imem_rdata   = word;
    dec_rf_wr_en = rfw;
    dec_jump     = jmp;
    dec_branch   = br;
    branch_cond  = cond;
    immediate    = imm;
    npc = m_pc + ((jmp || (br && cond)) ? imm : 32'd4);
    while (!(left && imem_req) && cyc < 60) begin
      if (imem_req && !left) begin
        if (imem_addr !== m_pc) abad++;
        imem_ready = (iwc == iw);
        iwc++;
      end else begin
        imem_ready = noise;
      end
      if (dmem_req) begin
        dmem_ready = (dwc == dw);
        dwc++;
        dreq++;
        if (dmem_we) we++;
      end else begin
        dmem_ready = noise;
      end
      if (rf_wr_en) begin
        rf++;
        rfc = cyc + 1;
      end
      if (cyc > 0 && retire) rets++;
      if (!imem_req) left = 1'b1;
      @(posedge clock); #1;
      cyc++;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    m_pc  = npc;
    m_ret = m_ret + 32'd1;
    chk({tag, "_timeout"}, {31'd0, cyc >= 60}, 32'd0);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_rf_pulses"}, rf, exp_rf);
    chk({tag, "_rf_cycle"}, rfc, exp_rfcyc);
    chk({tag, "_dmem_req"}, dreq, exp_dreq);
    chk({tag, "_dmem_we"}, we, exp_we);
    chk({tag, "_addr_stable"}, abad, 0);
    chk({tag, "_early_retire"}, rets, 0);
    chk({tag, "_retire"}, {31'd0, retire}, 32'd1);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_next_addr"}, imem_addr, m_pc);
    chk({tag, "_instret"}, instret, m_ret);
    chk({tag, "_ir"}, instruction, word);
  endtask

  initial begin
    int nreq;
    int nwr;
    int guard;
    reset_dut();

    //   tag      word          rfw  jmp  br   cond imm            iw dw noise cyc rf rfc dq we
    exec("add",   32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        0, 0, 1'b0, 4, 1, 4, 0, 0);
    exec("addi",  32'h00108093, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        0, 0, 1'b1, 4, 1, 4, 0, 0);
    exec("load",  32'h0000A103, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        0, 3, 1'b0, 8, 1, 8, 4, 0);
    exec("store", 32'h0020A023, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        0, 1, 1'b0, 5, 0, 0, 2, 2);
    exec("lui",   32'h000010B7, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        2, 0, 1'b0, 6, 1, 6, 0, 0);
    exec("jal_m4",32'hFFDFF0EF, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 0, 0, 1'b0, 4, 1, 4, 0, 0);
    chk("at_0x10", pc, 32'h10);
    exec("br_tk", 32'hFE000CE3, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF8, 0, 0, 1'b0, 3, 0, 0, 0, 0);
    chk("br_tk_dst", imem_addr, 32'h08);
    exec("jal_8", 32'h008000EF, 1'b1, 1'b1, 1'b0, 1'b0, 32'd8,        0, 0, 1'b0, 4, 1, 4, 0, 0);
    exec("br_nt", 32'hFE000CE3, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFF8, 0, 0, 1'b0, 3, 0, 0, 0, 0);
    chk("br_nt_dst", imem_addr, 32'h14);
    exec("jal_hi",32'hFE9FF0EF, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFE8, 0, 0, 1'b0, 4, 1, 4, 0, 0);
    chk("at_top", pc, 32'hFFFFFFFC);
    exec("jal_wr",32'h008000EF, 1'b1, 1'b1, 1'b0, 1'b0, 32'd8,        0, 0, 1'b0, 4, 1, 4, 0, 0);
    chk("wrap_pc", pc, 32'h4);
    chk("instret_11", instret, 32'd11);

    // illegal opcode: sticky halt, nothing requested or written afterwards
    imem_rdata   = 32'h0000007F;
    dec_rf_wr_en = 1'b1;
    imem_ready   = 1'b1;
    dmem_ready   = 1'b1;
    nreq = 0;
    nwr  = 0;
    @(posedge clock); #1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (imem_req) nreq++;
      if (dmem_req || dmem_we || rf_wr_en || retire) nwr++;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    chk("halt_state", {29'd0, state}, 32'd7);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_noreq", nreq, 0);
    chk("halt_nowr", nwr, 0);
    chk("halt_pc", pc, 32'h4);
    chk("halt_instret", instret, 32'd11);
    chk("halt_ir", instruction, 32'h0000007F);

    reset_dut();

    // reset asserted mid-MEM must drop dmem_req immediately
    exec("add2",  32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        0, 0, 1'b0, 4, 1, 4, 0, 0);
    imem_rdata = 32'h0020A023;
    imem_ready = 1'b1;
    guard = 0;
    while (!dmem_req && guard < 20) begin
      @(posedge clock); #1;
      imem_ready = 1'b0;
      guard++;
    end
    chk("mid_mem_reached", {31'd0, dmem_req}, 32'd1);
    chk("mid_mem_we", {31'd0, dmem_we}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("async_dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("async_state", {29'd0, state}, 32'd0);
    chk("async_pc", pc, 32'd0);
    chk("async_instret", instret, 32'd0);
    chk("async_retire", {31'd0, retire}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk("rel_boot", {29'd0, state}, 32'd0);
    chk("rel_noreq", {31'd0, imem_req}, 32'd0);
    @(posedge clock); #1;
    chk("rel_fetch", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
